// File: rtl/mult18_pkg.sv
// Shared widths and the sign-extension helper for the shared 18x18 signed multiplier.
package mult18_pkg;

    localparam int MULT_OPW = 18;
    localparam int MULT_PW  = 36;

    function automatic logic [MULT_PW-1:0] sext36(input logic [MULT_OPW-1:0] v);
        return {{(MULT_PW-MULT_OPW){v[MULT_OPW-1]}}, v};
    endfunction

endpackage

// File: rtl/mult18_signed_core.sv
// Purely combinational 18x18 signed multiply, kept as its own instance so it maps onto a hard multiplier.
module mult18_signed_core
    import mult18_pkg::*;
(
    input  logic [MULT_OPW-1:0] i_a,
    input  logic [MULT_OPW-1:0] i_b,
    output logic [MULT_PW-1:0]  o_p
);

    logic signed [MULT_PW-1:0] w_aExt;
    logic signed [MULT_PW-1:0] w_bExt;

    assign w_aExt = sext36(i_a);
    assign w_bExt = sext36(i_b);

    // Both operands are sign-extended to 36 bits first, so the truncated product is exact.
    assign o_p = w_aExt * w_bExt;

endmodule

// File: rtl/mult18_share_arb.sv
// Round-robin sharing of one signed 18x18 multiplier among NUM_REQ requesters,
// with an operand stage and a product stage under full backpressure.
module mult18_share_arb
    import mult18_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*MULT_OPW-1:0] req_a,
    input  logic [NUM_REQ*MULT_OPW-1:0] req_b,
    output logic [NUM_REQ-1:0]          rsp_valid,
    input  logic [NUM_REQ-1:0]          rsp_ready,
    output logic [MULT_PW-1:0]          rsp_p,
    output logic                        busy
);

    logic                r_s1Vld;
    logic [IDW-1:0]      r_s1Id;
    logic [MULT_OPW-1:0] r_s1A;
    logic [MULT_OPW-1:0] r_s1B;
    logic                r_s2Vld;
    logic [IDW-1:0]      r_s2Id;
    logic [MULT_PW-1:0]  r_s2P;
    logic [IDW-1:0]      r_rrPtr;

    logic                w_s2Stall;
    logic                w_s1Adv;
    logic                w_s1CanAccept;
    logic                w_found;
    logic [IDW-1:0]      w_grantId;
    logic [IDW-1:0]      w_nextPtr;
    logic                w_handshake;
    logic [MULT_PW-1:0]  w_prod;
    logic [MULT_OPW-1:0] w_reqA [NUM_REQ];
    logic [MULT_OPW-1:0] w_reqB [NUM_REQ];

    // Wrap is explicit modulo NUM_REQ so non-power-of-two counts never produce an unused id.
    function automatic logic [IDW-1:0] wrapAdd(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return IDW'(s);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_reqA[i] = req_a[i*MULT_OPW +: MULT_OPW];
            w_reqB[i] = req_b[i*MULT_OPW +: MULT_OPW];
        end
    end

    assign w_s2Stall     = r_s2Vld & ~rsp_ready[r_s2Id];
    assign w_s1Adv       = ~w_s2Stall;
    assign w_s1CanAccept = ~r_s1Vld | w_s1Adv;

    always_comb begin
        w_found   = 1'b0;
        w_grantId = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!w_found && req_valid[wrapAdd(r_rrPtr, off)]) begin
                w_found   = 1'b1;
                w_grantId = wrapAdd(r_rrPtr, off);
            end
        end
    end

    assign w_nextPtr   = wrapAdd(w_grantId, 1);
    assign w_handshake = reset_n & w_found & w_s1CanAccept;
    assign req_ready   = w_handshake ? (NUM_REQ'(1) << w_grantId) : '0;

    mult18_signed_core u_core (
        .i_a (r_s1A),
        .i_b (r_s1B),
        .o_p (w_prod)
    );

    // Data registers only load on a real transfer, so ungranted or X operands never leak in.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1Vld <= 1'b0;
            r_s1Id  <= '0;
            r_s1A   <= '0;
            r_s1B   <= '0;
            r_s2Vld <= 1'b0;
            r_s2Id  <= '0;
            r_s2P   <= '0;
            r_rrPtr <= '0;
        end else begin
            if (w_s1Adv) begin
                r_s2Vld <= r_s1Vld;
                if (r_s1Vld) begin
                    r_s2Id <= r_s1Id;
                    r_s2P  <= w_prod;
                end
            end
            if (w_handshake) begin
                r_s1Vld <= 1'b1;
                r_s1Id  <= w_grantId;
                r_s1A   <= w_reqA[w_grantId];
                r_s1B   <= w_reqB[w_grantId];
                r_rrPtr <= w_nextPtr;
            end else if (w_s1Adv) begin
                r_s1Vld <= 1'b0;
            end
        end
    end

    assign rsp_valid = r_s2Vld ? (NUM_REQ'(1) << r_s2Id) : '0;
    assign rsp_p     = r_s2P;
    assign busy      = r_s1Vld | r_s2Vld;

endmodule

// File: tb/tb_mult18_share_arb.sv
// Scoreboard bench for mult18_share_arb: directed corner cases followed by a randomized soak.
module tb_mult18_share_arb;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*18-1:0]   req_a;
    logic [N*18-1:0]   req_b;
    logic [N-1:0]      rsp_valid;
    logic [N-1:0]      rsp_ready;
    logic [35:0]       rsp_p;
    logic              busy;

    typedef struct {
        int          id;
        logic [35:0] p;
    } exp_t;

    exp_t sbq[$];
    int   rrPtr  = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mult18_share_arb #(.NUM_REQ(N), .IDW(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .busy      (busy)
    );

    // Reference product: plain 64-bit signed arithmetic, truncated to 36 bits.
    function automatic logic [35:0] refProd(input logic [17:0] a, input logic [17:0] b);
        logic signed [63:0] pa;
        logic signed [63:0] pb;
        logic signed [63:0] pr;
        pa = $signed(a);
        pb = $signed(b);
        pr = pa * pb;
        return pr[35:0];
    endfunction

    function automatic logic [17:0] randOp();
        case ($urandom_range(0, 7))
            0: return 18'h20000;
            1: return 18'h1FFFF;
            2: return 18'h00000;
            3: return 18'h3FFFF;
            default: return 18'($urandom);
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] r);
        req_valid = v;
        rsp_ready = r;
        #1;
    endtask

    task automatic setOps(input int i, input logic [17:0] a, input logic [17:0] b);
        req_a[i*18 +: 18] = a;
        req_b[i*18 +: 18] = b;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: models pipeline occupancy and round-robin order, and scores every response.
    always @(negedge clk) begin : monitor
        int           n;
        int           expId;
        logic         canAcc;
        logic [N-1:0] expReady;
        logic [N-1:0] hs;
        if (!reset_n) begin
            checkOutput("readyInReset", 64'(req_ready), 64'd0);
            sbq.delete();
            rrPtr = 0;
        end else begin
            n = sbq.size();
            checkOutput("inflightBound", 64'(n <= 2), 64'd1);
            checkOutput("readyOnehot", 64'($onehot0(req_ready)), 64'd1);
            checkOutput("rspOnehot", 64'($onehot0(rsp_valid)), 64'd1);
            checkOutput("busy", 64'(busy), 64'(n != 0));
            canAcc = (n < 2) || rsp_ready[sbq[0].id];
            expId = -1;
            for (int off = 0; off < N; off++) begin
                if (expId < 0 && req_valid[(rrPtr + off) % N]) expId = (rrPtr + off) % N;
            end
            expReady = (canAcc && expId >= 0) ? (N'(1) << expId) : '0;
            checkOutput("grant", 64'(req_ready), 64'(expReady));
            if (rsp_valid != '0) begin
                if (n == 0) begin
                    checkOutput("rspWhenEmpty", 64'(rsp_valid), 64'd0);
                end else begin
                    checkOutput("rspId", 64'(rsp_valid), 64'(N'(1) << sbq[0].id));
                    checkOutput("rspP", 64'(rsp_p), 64'(sbq[0].p));
                    if ((rsp_valid & rsp_ready) != '0) void'(sbq.pop_front());
                end
            end
            hs = req_valid & req_ready;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    sbq.push_back('{id: i, p: refProd(req_a[i*18 +: 18], req_b[i*18 +: 18])});
                    rrPtr = (i + 1) % N;
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        logic [35:0]  pX;
        logic [35:0]  pY;
        logic [35:0]  cornerExp [3];
        logic [17:0]  cornerA [3];
        logic [17:0]  cornerB [3];
        logic [N-1:0] hsPrev;
        int           guard;

        reset_n   = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        req_a     = '0;
        req_b     = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetRspValid", 64'(rsp_valid), 64'd0);
        checkOutput("resetRspP", 64'(rsp_p), 64'd0);
        checkOutput("resetBusy", 64'(busy), 64'd0);
        reset_n = 1'b1;

        $display("[TB] single request");
        setOps(0, 18'h3FFFD, 18'd5);
        applyStimulus(4'b0001, 4'b1111);
        checkOutput("singleReady", 64'(req_ready), 64'b0001);
        stepCycle();
        applyStimulus(4'b0000, 4'b1111);
        checkOutput("singleNoRspYet", 64'(rsp_valid), 64'd0);
        checkOutput("singleBusy", 64'(busy), 64'd1);
        stepCycle();
        checkOutput("singleRspValid", 64'(rsp_valid), 64'b0001);
        checkOutput("singleRspP", 64'(rsp_p), 64'hFFFFFFFF1);
        stepCycle();
        checkOutput("singleIdle", 64'(busy), 64'd0);

        $display("[TB] corner products");
        cornerA   = '{18'h20000, 18'h1FFFF, 18'h00000};
        cornerB   = '{18'h20000, 18'h20000, 18'h12345};
        cornerExp = '{36'h400000000, 36'hC00020000, 36'h000000000};
        for (int j = 0; j < 4; j++) begin
            if (j < 3) begin
                setOps(0, cornerA[j], cornerB[j]);
                applyStimulus(4'b0001, 4'b1111);
            end else begin
                applyStimulus(4'b0000, 4'b1111);
            end
            stepCycle();
            if (j >= 1) checkOutput($sformatf("corner%0d", j - 1), 64'(rsp_p), 64'(cornerExp[j-1]));
        end
        stepCycle();

        $display("[TB] backpressure on requester 2");
        setOps(2, 18'd1234, 18'h3FFF9);
        pX = refProd(18'd1234, 18'h3FFF9);
        applyStimulus(4'b0100, 4'b1011);
        stepCycle();
        setOps(2, 18'h3FE0C, 18'd300);
        pY = refProd(18'h3FE0C, 18'd300);
        #1;
        stepCycle();
        setOps(2, 18'd77, 18'd88);
        #1;
        for (int c = 0; c < 5; c++) begin
            checkOutput("stallHoldP", 64'(rsp_p), 64'(pX));
            checkOutput("stallRspValid", 64'(rsp_valid), 64'b0100);
            checkOutput("stallNoReady", 64'(req_ready), 64'd0);
            stepCycle();
        end
        applyStimulus(4'b0000, 4'b1111);
        checkOutput("releaseFirst", 64'(rsp_p), 64'(pX));
        stepCycle();
        checkOutput("releaseSecond", 64'(rsp_p), 64'(pY));
        checkOutput("releaseSecondId", 64'(rsp_valid), 64'b0100);
        stepCycle();

        $display("[TB] reset mid-flight and fairness");
        setOps(0, 18'd11, 18'd13);
        applyStimulus(4'b0001, 4'b0000);
        stepCycle();
        setOps(0, 18'd17, 18'd19);
        #1;
        stepCycle();
        applyStimulus(4'b0000, 4'b0000);
        reset_n = 1'b0;
        stepCycle();
        reset_n = 1'b1;
        #1;
        checkOutput("midResetRspValid", 64'(rsp_valid), 64'd0);
        checkOutput("midResetBusy", 64'(busy), 64'd0);
        applyStimulus(4'b1111, 4'b1111);
        checkOutput("fair0", 64'(req_ready), 64'b0001);
        stepCycle();
        checkOutput("fair1", 64'(req_ready), 64'b0010);
        stepCycle();
        checkOutput("fair2", 64'(req_ready), 64'b0100);
        stepCycle();
        checkOutput("fair3", 64'(req_ready), 64'b1000);
        stepCycle();
        checkOutput("fair4", 64'(req_ready), 64'b0001);
        stepCycle();
        applyStimulus(4'b0010, 4'b1111);
        checkOutput("fairReq1", 64'(req_ready), 64'b0010);
        stepCycle();
        applyStimulus(4'b1010, 4'b1111);
        checkOutput("fairPtr2Picks3", 64'(req_ready), 64'b1000);
        stepCycle();
        checkOutput("fairThen1", 64'(req_ready), 64'b0010);
        stepCycle();
        applyStimulus(4'b0000, 4'b1111);
        stepCycle();

        $display("[TB] random soak");
        for (int c = 0; c < 12000; c++) begin
            @(negedge clk);
            hsPrev = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hsPrev[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 99) < 60);
                    setOps(i, randOp(), randOp());
                end
                rsp_ready[i] = ($urandom_range(0, 99) < 75);
            end
        end
        applyStimulus(4'b0000, 4'b1111);
        guard = 0;
        while (busy && guard < 50) begin
            stepCycle();
            guard++;
        end
        @(negedge clk);
        #1;
        checkOutput("drainBusy", 64'(busy), 64'd0);
        checkOutput("drainQueue", 64'(sbq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult18_share_arb.md
Name: mult18_share_arb

Overview:
- Shares one signed 18x18 multiplier among NUM_REQ requesters, each with its own valid/ready operand and result channels.
- Round-robin arbitration; a 2-stage registered pipeline (operand register, product register) with full backpressure.
- Sits between the PicoBlaze I/O port decode / DSP helpers and a single multiplier resource.
- Sustains one product per cycle when uncontended.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDW, 2, requester-index width; must equal clog2(NUM_REQ), minimum 1.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  operand pair offered, one bit per requester.
- req_ready  out  NUM_REQ  one-hot grant; the handshake completes when req_valid[i] and req_ready[i] are both high.
- req_a  in  NUM_REQ*18  signed operand A; requester i uses bits [18i+17:18i].
- req_b  in  NUM_REQ*18  signed operand B; same packing as req_a.
- rsp_valid  out  NUM_REQ  one-hot; result present for requester i.
- rsp_ready  in  NUM_REQ  requester i accepts its result.
- rsp_p  out  36  signed product, shared by all requesters; qualified by rsp_valid.
- busy  out  1  high when either pipeline stage holds data.

Behaviour:
- Arithmetic:
  - P = sext36(A) * sext36(B), low 36 bits kept. This is exact for all 18-bit signed inputs.
  - -131072 * -131072 = +2^34, with no overflow.
- Stage S1 (operands): s1_vld, s1_id, s1_a, s1_b.
- Stage S2 (product): s2_vld, s2_id, s2_p.
- Stall rules:
  - s2_stall = s2_vld & ~rsp_ready[s2_id].
  - s1_adv = ~s2_stall. S2 loads from S1 whenever s1_adv is high.
  - S1 can accept = ~s1_vld | s1_adv.
- Arbitration (combinational):
  - The search starts at rr_ptr and wraps modulo NUM_REQ.
  - The first i with req_valid[i] set gets grant[i].
  - req_ready = grant when S1 can accept, otherwise all zero.
  - At most one bit of req_ready is ever high.
  - req_ready may depend on req_valid. A requester must not make req_valid depend on req_ready.
- On a handshake with requester i:
  - S1 captures A, B and id = i at the clock edge.
  - rr_ptr becomes (i+1) mod NUM_REQ.
  - rr_ptr is unchanged when there is no handshake.
- Latency:
  - Handshake at edge k: product registered at edge k+1, rsp_valid[id] high from edge k+1.
  - So the result is visible in the cycle after the handshake cycle.
  - Throughput: 1 per cycle with continuous rsp_ready.
- Outputs:
  - rsp_valid = s2_vld ? onehot(s2_id) : 0.
  - rsp_p = s2_p, held stable while stalled.
  - busy = s1_vld | s2_vld.
- Stall behaviour:
  - While s2_stall is high, S2 and S1 hold their contents.
  - req_ready is all zero if s1_vld; if S1 is empty, one new request may still enter S1.
  - Operands in S1 are never lost or overwritten.
- Result ordering: results are in acceptance order. A stalled requester blocks the others; head-of-line blocking is accepted.
- Simultaneous events:
  - A response accept and a new grant in the same cycle both take effect.
  - A requester that receives a result and re-requests in the same cycle is legal.
- Unused index: when NUM_REQ is not a power of two, ids >= NUM_REQ never arise; the wrap is explicit modulo NUM_REQ, not a bit-width wrap.
- Reset (reset_n low at an edge):
  - s1_vld = 0, s2_vld = 0, rr_ptr = 0, s2_p = 0, s1_a = s1_b = 0, ids = 0.
  - Outputs at reset: req_ready = 0 while reset_n is low, rsp_valid = 0, rsp_p = 0, busy = 0.
  - Reset mid-operation discards in-flight products; nothing is replayed.
- X-safety: s1/s2 data registers load only on an advance, so an X on an ungranted requester's operands never propagates.

Decomposition:
- Shared include mult18_pkg.vh:
  - MULT_OPW = 18, MULT_PW = 36.
  - Macro for onehot-from-index.
  - Sign-extend-to-36 helper function.
- Sub-module mult18_signed_core:
  - Purely combinational 18x18 signed multiply with 36-bit product.
  - Kept as a separate instance so synthesis can map it onto the MULT18X18 primitive.
  - Arbiter, pointer and pipeline stay in the top module.

Test Plan:
- Single request: req0 A = -3, B = 5 -> one cycle after the handshake, rsp_valid = 4'b0001, rsp_p = 36'hFFFFFFFF1; busy drops after rsp_ready.
- Corner products, one per cycle: (-131072)*(-131072) -> 36'h400000000; 131071*(-131072) -> 36'hC00020000; 0*x -> 0.
- Fairness: all 4 req_valid held high, rsp_ready all high -> grants in order 0,1,2,3,0 on consecutive cycles. Then rr_ptr = 2 with only req1 and req3 valid -> req3 granted first.
- Backpressure: req2 issues 2 back-to-back ops with rsp_ready[2] = 0 for 5 cycles -> rsp_p is stable with the first product and req_ready is all zero after S1 fills; on release both products arrive on consecutive cycles, in order.
- Reset mid-flight: reset_n low for 1 cycle while S1 and S2 are valid -> next cycle rsp_valid = 0, busy = 0, rr_ptr = 0 (req0 wins if all requesters request).
- Random soak: 10k random operands and random valid/ready against a sign-extended reference model -> every result matches, no drops or duplicates, req_ready and rsp_valid always at most one-hot.
